// File: rtl/actuator_sequencer_if.sv
// Command handshake between the processor and the actuator sequencer.
// The processor drives valid/target; the sequencer reports readiness.
interface actuator_sequencer_if;
    logic cmd_valid;
    logic cmd_pos;
    logic cmd_ready;

    modport master (output cmd_valid, output cmd_pos, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_pos, output cmd_ready);
endinterface

// File: rtl/actuator_sequencer.sv
// Two-position actuator stroke sequencer: commanded or autonomous strokes, then dwell.
// Define ACT_SEQ_ABORT_EN to add the abort input that cancels a stroke in progress.
module actuator_sequencer #(
    parameter int unsigned TRAVEL_CYCLES = 50000000,
    parameter int unsigned DWELL_CYCLES  = 25000000,
    parameter logic [7:0]  DUTY_EXTEND   = 8'd24,
    parameter logic [7:0]  DUTY_RETRACT  = 8'd12
) (
    input  logic                 clk,
    input  logic                 reset,
    actuator_sequencer_if.slave  cmd,
    input  logic                 auto_en,
`ifdef ACT_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    output logic [7:0]           duty_cycle,
    output logic                 position,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        DWELL = 2'd2
    } state_t;

    localparam logic [31:0] TRAVEL_LOAD = 32'(TRAVEL_CYCLES - 1);
    localparam logic [31:0] DWELL_LOAD  = 32'(DWELL_CYCLES - 1);

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic        target, target_nxt;
    logic        position_nxt;
    logic [7:0]  duty_nxt;
    logic        done_nxt;
    logic        req, req_pos, accept_ok;

    function automatic logic [7:0] duty_code(input logic pos);
        return pos ? DUTY_EXTEND : DUTY_RETRACT;
    endfunction

    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);

    // An explicit command always beats the autonomous toggle request.
    assign req     = cmd.cmd_valid | auto_en;
    assign req_pos = cmd.cmd_valid ? cmd.cmd_pos : ~position;

`ifdef ACT_SEQ_ABORT_EN
    assign accept_ok = ~abort;
`else
    assign accept_ok = 1'b1;
`endif

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        target_nxt   = target;
        position_nxt = position;
        duty_nxt     = duty_cycle;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (req && accept_ok) begin
                    target_nxt = req_pos;
                    if (req_pos != position) begin
                        state_nxt = MOVE;
                        duty_nxt  = duty_code(req_pos);
                        cnt_nxt   = TRAVEL_LOAD;
                    end else begin
                        // Already at the requested end: complete without travelling.
                        done_nxt = 1'b1;
                    end
                end
            end
            MOVE: begin
                if (cnt == 32'd0) begin
                    state_nxt    = DWELL;
                    position_nxt = target;
                    cnt_nxt      = DWELL_LOAD;
                end else begin
                    cnt_nxt = cnt - 32'd1;
                end
            end
            DWELL: begin
                if (cnt == 32'd0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 32'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 32'd0;
            end
        endcase

`ifdef ACT_SEQ_ABORT_EN
        // Abort leaves position as last completed and drives the matching duty code.
        if (abort && (state != IDLE)) begin
            state_nxt    = IDLE;
            cnt_nxt      = 32'd0;
            position_nxt = position;
            duty_nxt     = duty_code(position);
            done_nxt     = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 32'd0;
            target     <= 1'b0;
            position   <= 1'b0;
            duty_cycle <= DUTY_RETRACT;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            target     <= target_nxt;
            position   <= position_nxt;
            duty_cycle <= duty_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_actuator_sequencer.sv
// Directed-vector bench for actuator_sequencer with TRAVEL_CYCLES=8, DWELL_CYCLES=4.
// Abort scenario runs only when ACT_SEQ_ABORT_EN is defined.
module tb_actuator_sequencer;

    logic       clk;
    logic       reset;
    logic       auto_en;
    logic [7:0] duty_cycle;
    logic       position;
    logic       busy;
    logic       done;
`ifdef ACT_SEQ_ABORT_EN
    logic       abort;
`endif

    int vectors;
    int miscompares;

    actuator_sequencer_if cmd_if ();

    actuator_sequencer #(
        .TRAVEL_CYCLES(8),
        .DWELL_CYCLES (4),
        .DUTY_EXTEND  (8'd24),
        .DUTY_RETRACT (8'd12)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd_if),
        .auto_en   (auto_en),
`ifdef ACT_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .duty_cycle(duty_cycle),
        .position  (position),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_pos = 1'b1;
        tick();
        tick();
        vectors++; if (duty_cycle !== 8'd12) begin $display("FAIL reset_duty: got %0d expected 12", duty_cycle); miscompares++; end
        vectors++; if (position !== 1'b0) begin $display("FAIL reset_position: got %0b expected 0", position); miscompares++; end
        vectors++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %0b expected 0", busy); miscompares++; end
        vectors++; if (done !== 1'b0) begin $display("FAIL reset_done: got %0b expected 0", done); miscompares++; end
        vectors++; if (cmd_if.cmd_ready !== 1'b1) begin $display("FAIL reset_ready: got %0b expected 1", cmd_if.cmd_ready); miscompares++; end
        cmd_if.cmd_valid = 1'b0;
        reset = 1'b0;
        #2;
        vectors++; if (cmd_if.cmd_ready !== 1'b1) begin $display("FAIL post_reset_ready: got %0b expected 1", cmd_if.cmd_ready); miscompares++; end
    endtask

    task automatic test_stroke();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_pos = 1'b1;
        tick();
        cmd_if.cmd_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            vectors++; if (busy !== 1'b1) begin $display("FAIL stroke_busy[%0d]: got %0b expected 1", k, busy); miscompares++; end
            vectors++; if (duty_cycle !== 8'd24) begin $display("FAIL stroke_duty[%0d]: got %0d expected 24", k, duty_cycle); miscompares++; end
            vectors++; if (position !== (k >= 8)) begin $display("FAIL stroke_position[%0d]: got %0b expected %0b", k, position, (k >= 8)); miscompares++; end
            vectors++; if (done !== 1'b0) begin $display("FAIL stroke_done_early[%0d]: got %0b expected 0", k, done); miscompares++; end
            tick();
        end
        vectors++; if (busy !== 1'b0) begin $display("FAIL stroke_end_busy: got %0b expected 0", busy); miscompares++; end
        vectors++; if (done !== 1'b1) begin $display("FAIL stroke_end_done: got %0b expected 1", done); miscompares++; end
        vectors++; if (cmd_if.cmd_ready !== 1'b1) begin $display("FAIL stroke_end_ready: got %0b expected 1", cmd_if.cmd_ready); miscompares++; end
        tick();
        vectors++; if (done !== 1'b0) begin $display("FAIL stroke_done_width: got %0b expected 0", done); miscompares++; end
    endtask

    task automatic test_zero_travel();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_pos = 1'b1;
        tick();
        cmd_if.cmd_valid = 1'b0;
        vectors++; if (busy !== 1'b0) begin $display("FAIL zero_busy: got %0b expected 0", busy); miscompares++; end
        vectors++; if (duty_cycle !== 8'd24) begin $display("FAIL zero_duty: got %0d expected 24", duty_cycle); miscompares++; end
        vectors++; if (done !== 1'b1) begin $display("FAIL zero_done: got %0b expected 1", done); miscompares++; end
        tick();
        vectors++; if (done !== 1'b0) begin $display("FAIL zero_done_width: got %0b expected 0", done); miscompares++; end
    endtask

    // Starts at position 1: retract over cycles 0..12, extend 13..25, retract 26..38, extend from 39.
    task automatic test_auto();
        logic [7:0] exp_duty;
        logic       exp_done;
        int         done_count;
        done_count = 0;
        auto_en = 1'b1;
        for (int j = 0; j < 40; j++) begin
            tick();
            exp_duty = ((j <= 12) || (j >= 26 && j <= 38)) ? 8'd12 : 8'd24;
            exp_done = (j == 12) || (j == 25) || (j == 38);
            if (done === 1'b1) done_count++;
            vectors++; if (duty_cycle !== exp_duty) begin $display("FAIL auto_duty[%0d]: got %0d expected %0d", j, duty_cycle, exp_duty); miscompares++; end
            vectors++; if (done !== exp_done) begin $display("FAIL auto_done[%0d]: got %0b expected %0b", j, done, exp_done); miscompares++; end
            vectors++; if (busy !== !exp_done) begin $display("FAIL auto_busy[%0d]: got %0b expected %0b", j, busy, !exp_done); miscompares++; end
        end
        vectors++; if (done_count != 3) begin $display("FAIL auto_done_count: got %0d expected 3", done_count); miscompares++; end
        auto_en = 1'b0;
        for (int j = 40; j < 52; j++) tick();
        vectors++; if (done !== 1'b1) begin $display("FAIL auto_off_done: got %0b expected 1", done); miscompares++; end
        vectors++; if (position !== 1'b1) begin $display("FAIL auto_off_position: got %0b expected 1", position); miscompares++; end
        for (int j = 0; j < 3; j++) begin
            tick();
            vectors++; if (busy !== 1'b0) begin $display("FAIL auto_off_idle[%0d]: got %0b expected 0", j, busy); miscompares++; end
        end
    endtask

    task automatic test_priority();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_pos = 1'b0;
        tick();
        cmd_if.cmd_valid = 1'b0;
        for (int j = 0; j < 13; j++) tick();
        vectors++; if (position !== 1'b0) begin $display("FAIL prio_setup_position: got %0b expected 0", position); miscompares++; end
        auto_en = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_pos = 1'b0;
        tick();
        auto_en = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        vectors++; if (busy !== 1'b0) begin $display("FAIL prio_busy: got %0b expected 0", busy); miscompares++; end
        vectors++; if (done !== 1'b1) begin $display("FAIL prio_done: got %0b expected 1", done); miscompares++; end
        vectors++; if (duty_cycle !== 8'd12) begin $display("FAIL prio_duty: got %0d expected 12", duty_cycle); miscompares++; end
        tick();
        vectors++; if (busy !== 1'b0) begin $display("FAIL prio_idle: got %0b expected 0", busy); miscompares++; end
    endtask

    task automatic test_reset_mid_stroke();
        int done_seen;
        // Reset in MOVE cycle 5.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_pos = 1'b1;
        tick();
        cmd_if.cmd_valid = 1'b0;
        for (int j = 0; j < 4; j++) tick();
        reset = 1'b1;
        #1;
        vectors++; if (duty_cycle !== 8'd12) begin $display("FAIL rst_move_duty: got %0d expected 12", duty_cycle); miscompares++; end
        vectors++; if (position !== 1'b0) begin $display("FAIL rst_move_position: got %0b expected 0", position); miscompares++; end
        vectors++; if (busy !== 1'b0) begin $display("FAIL rst_move_busy: got %0b expected 0", busy); miscompares++; end
        tick();
        reset = 1'b0;
        // Reset in DWELL after position has already flipped.
        cmd_if.cmd_valid = 1'b1;
        tick();
        cmd_if.cmd_valid = 1'b0;
        for (int j = 0; j < 9; j++) tick();
        vectors++; if (position !== 1'b1) begin $display("FAIL rst_dwell_setup: got %0b expected 1", position); miscompares++; end
        reset = 1'b1;
        #1;
        vectors++; if (position !== 1'b0) begin $display("FAIL rst_dwell_position: got %0b expected 0", position); miscompares++; end
        vectors++; if (duty_cycle !== 8'd12) begin $display("FAIL rst_dwell_duty: got %0d expected 12", duty_cycle); miscompares++; end
        tick();
        reset = 1'b0;
        done_seen = 0;
        for (int j = 0; j < 14; j++) begin
            tick();
            if (done !== 1'b0) done_seen++;
        end
        vectors++; if (done_seen != 0) begin $display("FAIL rst_no_done: got %0d pulses expected 0", done_seen); miscompares++; end
    endtask

`ifdef ACT_SEQ_ABORT_EN
    task automatic test_abort();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_pos = 1'b1;
        tick();
        cmd_if.cmd_valid = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++; if (busy !== 1'b0) begin $display("FAIL abort_busy: got %0b expected 0", busy); miscompares++; end
        vectors++; if (duty_cycle !== 8'd12) begin $display("FAIL abort_duty: got %0d expected 12", duty_cycle); miscompares++; end
        vectors++; if (position !== 1'b0) begin $display("FAIL abort_position: got %0b expected 0", position); miscompares++; end
        vectors++; if (done !== 1'b0) begin $display("FAIL abort_done: got %0b expected 0", done); miscompares++; end
        tick();
        vectors++; if (done !== 1'b0) begin $display("FAIL abort_done_late: got %0b expected 0", done); miscompares++; end
        abort = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        tick();
        abort = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        vectors++; if (busy !== 1'b0) begin $display("FAIL abort_idle_block: got %0b expected 0", busy); miscompares++; end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        auto_en = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_pos = 1'b0;
`ifdef ACT_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_stroke();
        test_zero_travel();
        test_auto();
        test_priority();
        test_reset_mid_stroke();
`ifdef ACT_SEQ_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/actuator_sequencer.md
ACTUATOR_SEQUENCER -- requirements
Module: actuator_sequencer

Interface
REQ-001 SHALL have parameter TRAVEL_CYCLES, default 50000000, clk cycles a stroke is driven (legal >= 1).
REQ-002 SHALL have parameter DWELL_CYCLES, default 25000000, clk cycles held at an end before the next command is accepted (legal >= 1).
REQ-003 SHALL have parameter DUTY_EXTEND, default 8'd24, duty code for the extend target.
REQ-004 SHALL have parameter DUTY_RETRACT, default 8'd12, duty code for the retract target.
REQ-005 SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port cmd_valid  input  1  processor requests a stroke.
REQ-008 SHALL have port cmd_pos  input  1  requested target: 1 = extend, 0 = retract.
REQ-009 SHALL have port cmd_ready  output  1  command can be accepted this cycle.
REQ-010 SHALL have port auto_en  input  1  enable autonomous extend/retract cycling.
REQ-011 SHALL have port duty_cycle  output  8  registered duty code to the PWM generator.
REQ-012 SHALL have port position  output  1  last completed end: 1 = extended, 0 = retracted.
REQ-013 SHALL have port busy  output  1  stroke or dwell in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse on stroke completion.

Function
REQ-015 SHALL implement states IDLE, MOVE, DWELL; cmd_ready = 1 only in IDLE (combinational from state); busy = 1 in MOVE and DWELL.
REQ-016 SHALL accept a command on a rising edge where state is IDLE and cmd_valid = 1; cmd_pos is captured as target at that edge.
REQ-017 SHALL, when in IDLE with auto_en = 1 and cmd_valid = 0, issue an internal command with target = ~position; cmd_valid has strict priority over auto.
REQ-018 SHALL, on accept with target != position, enter MOVE at that edge, set duty_cycle to the target's duty code, load a 32-bit down-counter with TRAVEL_CYCLES-1.
REQ-019 SHALL, on accept with target == position, stay IDLE, leave duty_cycle unchanged, and pulse done on the following cycle (zero-travel completion).
REQ-020 SHALL decrement the counter each cycle in MOVE; on the edge where counter = 0, enter DWELL, set position to target, reload counter with DWELL_CYCLES-1; MOVE therefore lasts exactly TRAVEL_CYCLES cycles.
REQ-021 SHALL hold duty_cycle at the target code throughout DWELL; on the edge where counter = 0 enter IDLE and assert done for exactly the next cycle; DWELL lasts exactly DWELL_CYCLES cycles.
REQ-022 SHALL keep duty_cycle equal to the code for position in IDLE.
REQ-023 SHALL ignore cmd_valid and auto_en changes during MOVE/DWELL; deasserting auto_en mid-stroke lets the stroke and dwell complete, then no further auto command issues.
REQ-024 SHALL never let done be asserted simultaneously for two strokes; back-to-back auto strokes separated by at least one IDLE cycle.

Reset
REQ-025 SHALL, while reset = 1 (asynchronously), force state IDLE, position = 0, duty_cycle = DUTY_RETRACT, counter = 0, done = 0, busy = 0.
REQ-026 SHALL, on reset mid-MOVE or mid-DWELL, abandon the stroke with no done pulse; position reverts to 0.
REQ-027 SHALL present cmd_ready = 1 during and immediately after reset, but accept nothing while reset = 1.

Configuration
REQ-028 SHALL, with macro ACT_SEQ_ABORT_EN defined, add port abort (input, 1): abort = 1 in MOVE or DWELL returns to IDLE at the next edge, position unchanged if in MOVE, duty_cycle restored to the code for position, no done pulse; abort in IDLE has no effect and takes priority over accept in that cycle.
REQ-029 SHALL, with ACT_SEQ_ABORT_EN undefined, omit the abort port and all abort logic; strokes always complete.

Verification (TRAVEL_CYCLES=8, DWELL_CYCLES=4)
REQ-030 SHALL test: reset released, cmd_valid=1 cmd_pos=1 one cycle -> duty_cycle 24 next cycle, busy 1 for 12 cycles, position 1 after 8, done pulse on cycle 13, cmd_ready returns 1.
REQ-031 SHALL test: position=1, cmd_pos=1 accepted -> duty stays 24, busy stays 0, done pulse next cycle.
REQ-032 SHALL test: auto_en=1, no commands, 40 cycles -> duty alternates 24/12 with period 26 cycles (12+1 per stroke), done once per stroke.
REQ-033 SHALL test: auto_en=1 and cmd_valid=1 cmd_pos=0 with position 0 -> command wins, zero-travel done, no MOVE that cycle.
REQ-034 SHALL test: reset asserted at MOVE cycle 5 -> duty_cycle 12, position 0, busy 0 immediately, no done pulse.
REQ-035 SHALL test (ACT_SEQ_ABORT_EN): abort at MOVE cycle 3 of retract->extend -> IDLE next edge, duty 12, position 0, no done.
